// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI serial-SRAM responder.
package idli_pkg;

  // Direction of the sio pins from the point of view of the owning block.
  typedef enum logic {
    SQI_IO_MODE_IN  = 1'b0,
    SQI_IO_MODE_OUT = 1'b1
  } sqi_io_mode_t;

  // Instruction bytes understood by the SQI SRAM responder.
  localparam logic [7:0] SQI_INSTR_READ  = 8'h03;
  localparam logic [7:0] SQI_INSTR_WRITE = 8'h02;

  // Nibble counts of the fixed-length transaction phases.
  localparam int SQI_ADDR_NIBBLES  = 6;
  localparam int SQI_DUMMY_NIBBLES = 2;

  // Responder FSM states.
  typedef enum logic [2:0] {
    SQI_SRAM_IDLE   = 3'd0,
    SQI_SRAM_INSTR  = 3'd1,
    SQI_SRAM_ADDR   = 3'd2,
    SQI_SRAM_DUMMY  = 3'd3,
    SQI_SRAM_RDATA  = 3'd4,
    SQI_SRAM_WDATA  = 3'd5,
    SQI_SRAM_IGNORE = 3'd6
  } sqi_sram_state_t;

endpackage

// File: rtl/idli_sqi_sram_m_if.sv
// SQI memory bus between the core (master) and the serial SRAM (slave).
// Framing: a transaction is every rising gck edge with i_sqi_cs low; the
// master presents one nibble per edge on i_sqi_sio, the slave answers on
// o_sqi_sio only while o_sqi_io_mode is OUT. Raising cs ends the transaction.
interface idli_sqi_sram_m_if;
  import idli_pkg::*;

  logic         i_sqi_cs;
  logic [3:0]   i_sqi_sio;
  logic [3:0]   o_sqi_sio;
  sqi_io_mode_t o_sqi_io_mode;

  modport master (
    output i_sqi_cs,
    output i_sqi_sio,
    input  o_sqi_sio,
    input  o_sqi_io_mode
  );

  modport slave (
    input  i_sqi_cs,
    input  i_sqi_sio,
    output o_sqi_sio,
    output o_sqi_io_mode
  );
endinterface

// File: rtl/idli_sqi_sram_m.sv
// SQI serial-SRAM responder: decodes quad READ/WRITE transactions and serves
// them from an internal byte array. Each gck rising edge is one nibble cycle.
module idli_sqi_sram_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic             i_sqi_gck,
  input  logic             i_sqi_rst_n,
  idli_sqi_sram_m_if.slave sqi,
  output sqi_sram_state_t  o_sqi_state
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]      mem [DEPTH];

  sqi_sram_state_t state_q;
  logic [2:0]      cnt_q;
  logic [AW-1:0]   addr_q;
  logic [3:0]      instr_hi_q;
  logic            is_read_q;
  logic [3:0]      wnib_q;
  logic [3:0]      sio_q;
  sqi_io_mode_t    io_mode_q;

  logic [7:0]      instr_d;
  logic [AW+3:0]   addr_shift_d;
  logic [7:0]      rd_byte;
  logic            mem_we;

  // Full instruction byte is formed on the edge that samples its low nibble.
  assign instr_d      = {instr_hi_q, sqi.i_sqi_sio};
  // Shifting the 24-bit address through an AW-bit register keeps only the
  // low address bits; upper bits simply fall off the top.
  assign addr_shift_d = {addr_q, sqi.i_sqi_sio};
  assign rd_byte      = mem[addr_q];
  // A byte lands on the edge that samples its low nibble, never under reset.
  assign mem_we       = (state_q == SQI_SRAM_WDATA) && cnt_q[0] &&
                        !sqi.i_sqi_cs && i_sqi_rst_n;

  // Transaction FSM with registered sio/io_mode outputs.
  // In RDATA/WDATA cnt_q[0] tracks which half of the byte comes next.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      state_q    <= SQI_SRAM_IDLE;
      cnt_q      <= 3'd0;
      addr_q     <= '0;
      instr_hi_q <= 4'h0;
      is_read_q  <= 1'b0;
      wnib_q     <= 4'h0;
      sio_q      <= 4'h0;
      io_mode_q  <= SQI_IO_MODE_IN;
    end else if (sqi.i_sqi_cs) begin
      state_q   <= SQI_SRAM_IDLE;
      cnt_q     <= 3'd0;
      wnib_q    <= 4'h0;
      sio_q     <= 4'h0;
      io_mode_q <= SQI_IO_MODE_IN;
    end else begin
      case (state_q)
        SQI_SRAM_IDLE: begin
          instr_hi_q <= sqi.i_sqi_sio;
          cnt_q      <= 3'd1;
          state_q    <= SQI_SRAM_INSTR;
        end
        SQI_SRAM_INSTR: begin
          if (cnt_q == 3'd1) begin
            cnt_q <= 3'd0;
            if (instr_d == SQI_INSTR_READ) begin
              is_read_q <= 1'b1;
              state_q   <= SQI_SRAM_ADDR;
            end else if (instr_d == SQI_INSTR_WRITE) begin
              is_read_q <= 1'b0;
              state_q   <= SQI_SRAM_ADDR;
            end else begin
              state_q <= SQI_SRAM_IGNORE;
            end
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        SQI_SRAM_ADDR: begin
          addr_q <= addr_shift_d[AW-1:0];
          if (cnt_q == 3'(SQI_ADDR_NIBBLES - 1)) begin
            cnt_q   <= 3'd0;
            state_q <= is_read_q ? SQI_SRAM_DUMMY : SQI_SRAM_WDATA;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        SQI_SRAM_DUMMY: begin
          if (cnt_q == 3'(SQI_DUMMY_NIBBLES - 1)) begin
            // High nibble goes out on the last dummy edge; cnt_q=1 marks
            // that the low nibble is next.
            cnt_q     <= 3'd1;
            state_q   <= SQI_SRAM_RDATA;
            io_mode_q <= SQI_IO_MODE_OUT;
            sio_q     <= rd_byte[7:4];
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        SQI_SRAM_RDATA: begin
          if (cnt_q[0]) begin
            sio_q  <= rd_byte[3:0];
            addr_q <= addr_q + 1'b1;
            cnt_q  <= 3'd0;
          end else begin
            sio_q <= rd_byte[7:4];
            cnt_q <= 3'd1;
          end
        end
        SQI_SRAM_WDATA: begin
          if (cnt_q[0]) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= 3'd0;
          end else begin
            wnib_q <= sqi.i_sqi_sio;
            cnt_q  <= 3'd1;
          end
        end
        default: begin
          // IGNORE: hold until cs rises.
        end
      endcase
    end
  end

  // Single write port into the storage array; contents survive reset.
  always_ff @(posedge i_sqi_gck) begin
    if (mem_we) begin
      mem[addr_q] <= {wnib_q, sqi.i_sqi_sio};
    end
  end

  assign sqi.o_sqi_sio     = sio_q;
  assign sqi.o_sqi_io_mode = io_mode_q;
  assign o_sqi_state       = state_q;

endmodule

// File: tb/tb_idli_sqi_sram_m.sv
// Self-checking bench for idli_sqi_sram_m: drives SQI transactions nibble by
// nibble and checks read data against a byte-array model via a scoreboard.
module tb_idli_sqi_sram_m;
  import idli_pkg::*;

  localparam int DEPTH = 256;

  logic clk;
  logic rst_n;
  sqi_sram_state_t state;

  idli_sqi_sram_m_if bus();

  idli_sqi_sram_m #(.DEPTH(DEPTH)) dut (
    .i_sqi_gck   (clk),
    .i_sqi_rst_n (rst_n),
    .sqi         (bus.slave),
    .o_sqi_state (state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] model [DEPTH];
  logic [7:0] wbuf [16];
  logic [4:0] exp_q [$];

  // Driver tasks: inputs change on the falling edge, outputs read after it.
  task automatic cycle(input logic cs, input logic [3:0] nib);
    bus.i_sqi_cs  = cs;
    bus.i_sqi_sio = nib;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_header(input logic [7:0] instr, input logic [23:0] addr);
    cycle(1'b0, instr[7:4]);
    cycle(1'b0, instr[3:0]);
    for (int i = 0; i < 6; i++) cycle(1'b0, addr[23-4*i -: 4]);
  endtask

  task automatic end_txn(input string name);
    cycle(1'b1, 4'h0);
    checks++;
    if (bus.o_sqi_io_mode !== SQI_IO_MODE_IN || bus.o_sqi_sio !== 4'h0 ||
        state !== SQI_SRAM_IDLE) begin
      errors++;
      $display("FAIL %s: got mode=%0b sio=%h state=%0d expected mode=0 sio=0 state=0",
               name, bus.o_sqi_io_mode, bus.o_sqi_sio, state);
    end
  endtask

  // Writes n bytes from wbuf starting at addr; updates the model.
  task automatic do_write(input logic [23:0] addr, input int n);
    send_header(SQI_INSTR_WRITE, addr);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, wbuf[i][7:4]);
      cycle(1'b0, wbuf[i][3:0]);
      model[(int'(addr[7:0]) + i) % DEPTH] = wbuf[i];
    end
  endtask

  // Reads n bytes from addr; expected nibbles come from the model.
  task automatic read_txn(input string name, input logic [23:0] addr, input int n);
    logic [4:0] got;
    logic [4:0] exp;
    logic [7:0] b;
    send_header(SQI_INSTR_READ, addr);
    cycle(1'b0, 4'($urandom_range(0, 15)));
    checks++;
    if (bus.o_sqi_io_mode !== SQI_IO_MODE_IN) begin
      errors++;
      $display("FAIL %s_dummy_mode: got %0b expected 0", name, bus.o_sqi_io_mode);
    end
    for (int i = 0; i < n; i++) begin
      b = model[(int'(addr[7:0]) + i) % DEPTH];
      exp_q.push_back({1'b1, b[7:4]});
      exp_q.push_back({1'b1, b[3:0]});
    end
    cycle(1'b0, 4'($urandom_range(0, 15)));
    for (int k = 0; k < 2 * n; k++) begin
      if (k > 0) cycle(1'b0, 4'($urandom_range(0, 15)));
      got = {logic'(bus.o_sqi_io_mode), bus.o_sqi_sio};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s_nib%0d: got mode/sio=%h expected %h", name, k, got, exp);
      end
    end
    end_txn({name, "_end"});
  endtask

  task automatic test_reset();
    bus.i_sqi_cs  = 1'b1;
    bus.i_sqi_sio = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_sqi_io_mode !== SQI_IO_MODE_IN || bus.o_sqi_sio !== 4'h0 ||
        state !== SQI_SRAM_IDLE) begin
      errors++;
      $display("FAIL reset: got mode=%0b sio=%h state=%0d expected 0/0/0",
               bus.o_sqi_io_mode, bus.o_sqi_sio, state);
    end
    rst_n = 1'b1;
    cycle(1'b1, 4'h0);
  endtask

  task automatic test_write_read();
    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    do_write(24'h000010, 2);
    end_txn("wr_end");
    read_txn("rd_10", 24'h000010, 2);
  endtask

  task automatic test_wrap();
    wbuf[0] = 8'h77;
    wbuf[1] = 8'h88;
    do_write(24'(DEPTH - 1), 2);
    end_txn("wrap_wr_end");
    read_txn("wrap_rd", 24'(DEPTH - 1), 2);
    read_txn("wrap_rd0", 24'h000000, 1);
  endtask

  task automatic test_partial_write();
    wbuf[0] = 8'h5A;
    do_write(24'h000021, 1);
    end_txn("pre21_end");
    wbuf[0] = 8'h11;
    do_write(24'h000020, 1);
    cycle(1'b0, 4'hF);
    end_txn("partial_end");
    read_txn("partial_rd", 24'h000020, 2);
  endtask

  task automatic test_ignore();
    wbuf[0] = 8'hC3;
    do_write(24'h000055, 1);
    end_txn("pre55_end");
    cycle(1'b0, 4'hF);
    cycle(1'b0, 4'hF);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 4'h5);
      checks++;
      if (bus.o_sqi_io_mode !== SQI_IO_MODE_IN || bus.o_sqi_sio !== 4'h0) begin
        errors++;
        $display("FAIL ignore_out%0d: got mode=%0b sio=%h expected 0/0",
                 i, bus.o_sqi_io_mode, bus.o_sqi_sio);
      end
    end
    checks++;
    if (state !== SQI_SRAM_IGNORE) begin
      errors++;
      $display("FAIL ignore_state: got %0d expected %0d", state, SQI_SRAM_IGNORE);
    end
    end_txn("ignore_end");
    read_txn("ignore_rd55", 24'h000055, 1);
    read_txn("ignore_rd10", 24'h000010, 2);
  endtask

  task automatic test_reset_mid_read();
    send_header(SQI_INSTR_READ, 24'h000010);
    cycle(1'b0, 4'h0);
    cycle(1'b0, 4'h0);
    checks++;
    if (bus.o_sqi_io_mode !== SQI_IO_MODE_OUT || bus.o_sqi_sio !== model[8'h10][7:4]) begin
      errors++;
      $display("FAIL midrd_first: got mode=%0b sio=%h expected 1/%h",
               bus.o_sqi_io_mode, bus.o_sqi_sio, model[8'h10][7:4]);
    end
    cycle(1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_sqi_io_mode !== SQI_IO_MODE_IN || bus.o_sqi_sio !== 4'h0 ||
        state !== SQI_SRAM_IDLE) begin
      errors++;
      $display("FAIL async_reset: got mode=%0b sio=%h state=%0d expected 0/0/0",
               bus.o_sqi_io_mode, bus.o_sqi_sio, state);
    end
    bus.i_sqi_cs = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 4'h0);
    read_txn("post_reset_rd", 24'h000010, 2);
  endtask

  task automatic test_alias();
    read_txn("alias_rd", 24'hFFFF10, 2);
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(24'hABCD30, 1);
    end_txn("alias_wr_end");
    read_txn("alias_rd30", 24'h000030, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
    do_write(24'h000040, 4);
    end_txn("b2b_wr_end");
    read_txn("b2b_rd", 24'h000040, 4);
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(24'h000043, 1);
    end_txn("b2b_wr2_end");
    read_txn("b2b_rd2", 24'h000042, 2);
  endtask

  initial begin
    bus.i_sqi_cs  = 1'b1;
    bus.i_sqi_sio = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_wrap();
    test_partial_write();
    test_ignore();
    test_reset_mid_read();
    test_alias();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idli_sqi_sram_m.md
# idli_sqi_sram_m

Synthesizable SQI serial-SRAM responder: the memory-side end of the core's `mem_*` interface (sck/cs/io_mode/sio). It decodes quad-mode READ and WRITE transactions issued by `idli_core_m` and serves them from an internal byte array. It is used as the memory model in simulation and FPGA bring-up. It runs on the same global clock the core forwards as `sck`, so each `gck` rising edge is one SQI nibble cycle.

## Interface
- `DEPTH`, default 256: bytes of storage; power of two, at least 16.
- `i_sqi_gck` in 1: global clock; equals the core's `o_core_mem_sck`.
- `i_sqi_rst_n` in 1: asynchronous active-low reset.
- `i_sqi_cs` in 1: chip select, active low; from `o_core_mem_cs`.
- `i_sqi_sio` in 4: nibble from the initiator; from `o_core_mem_sio`.
- `o_sqi_sio` out 4: nibble driven to the initiator; to `i_core_mem_sio`.
- `o_sqi_io_mode` out 1: `sqi_io_mode_t` from the responder's view. OUT while driving read data, IN otherwise.

## Operation
- A transaction is every rising edge with `i_sqi_cs`=0. Cycle 0 is the first such edge. All fields are sent high nibble first.
- Cycles 0-1 carry the instruction byte. Cycles 2-7 carry the 24-bit address. Only `addr[$clog2(DEPTH)-1:0]` is kept; the upper bits are ignored.
- READ (8'h03):
  - Cycles 8-9 are dummy cycles; input is ignored.
  - Byte stream from the address, high nibble then low nibble, until cs rises.
  - The address increments after each low nibble and wraps DEPTH-1 to 0.
- WRITE (8'h02):
  - From cycle 8, nibble pairs form bytes.
  - The byte is written on the edge that samples its low nibble. The address then increments, with the same wrap as READ.
- Any other instruction: go to IGNORE; no reads, no writes, outputs idle until cs rises.
- FSM states:
  - IDLE: on cs=0, go to INSTR.
  - INSTR: after 2 nibbles, go to ADDR (valid instruction) or IGNORE (other).
  - ADDR: after 6 nibbles, go to DUMMY (READ) or WDATA (WRITE).
  - DUMMY: after 2 nibbles, go to RDATA.
  - RDATA and WDATA: stay until cs rises.
  - IGNORE: stay until cs rises.
  - A 3-bit nibble counter times every state.
- cs=1 on any edge: go to IDLE, clear the counter, and drop any half-collected write byte. A byte already written stays written.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM is IDLE, counter 0, `o_sqi_sio`=4'h0, `o_sqi_io_mode`=IN.
  - The storage array is not reset; its contents are undefined at power-up and kept across resets.
- Reset mid-transaction aborts it immediately. A write only completes on an edge where reset is deasserted.
- Outputs are registered.
  - `o_sqi_io_mode` becomes OUT on the edge that samples cycle 9.
  - `o_sqi_sio` shows the high nibble of byte[addr] from that same edge.
  - Each later edge with cs=0 advances one nibble.
- The edge that samples cs=1 sets io_mode=IN and sio=4'h0.
- Read-after-write within one transaction is impossible. A READ started on the cycle after a WRITE's final byte edge returns the new data.
- Array read is combinational from the address register, fed into the output register. The read path has no extra latency beyond the two dummy cycles.

## Structure
- Shared package `idli_pkg`:
  - Existing `sqi_io_mode_t`.
  - New constants `SQI_INSTR_READ`=8'h03 and `SQI_INSTR_WRITE`=8'h02.
  - New enum `sqi_sram_state_t` (IDLE, INSTR, ADDR, DUMMY, RDATA, WDATA, IGNORE).
  - New localparams `SQI_ADDR_NIBBLES`=6 and `SQI_DUMMY_NIBBLES`=2.
- No sub-module. Storage is an inline `logic [7:0] mem [DEPTH]` with a single write port.

## Test plan
- WRITE, address 0x000010, data 8'hA5, 8'h3C, then cs high; READ at 0x000010 -> cycles 10-13 drive A,5,3,C with io_mode=OUT; io_mode=IN on the cs-high edge.
- WRITE 8'h77 at DEPTH-1 and 8'h88 at the wrapped address; READ two bytes from DEPTH-1 -> 7,7,8,8, and byte 0 = 8'h88.
- WRITE at 0x20: one full byte 8'h11, then one nibble 4'hF, then cs high -> 0x20 = 8'h11 and 0x21 unchanged.
- Instruction 8'hFF followed by 20 nibbles of 4'h5 -> io_mode stays IN, sio stays 0, array unchanged.
- Assert reset during a READ's data phase -> sio=0 and io_mode=IN asynchronously; after release, a new READ works and data written earlier is intact.
- Address 24'hFFFF10 with DEPTH=256 -> aliases byte 0x10.
